// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment display blocks.
//   SEG_HEX_LUT  : hex digit -> {g,f,e,d,c,b,a} segment code (active high)
//   SEG_DOT_BIT  : bit position of the decimal point in an 8-bit segment bus
//   seg_entry_t  : one digit register entry {dot, hex}
//   onehot()     : 16-bit one-hot of an index, zero when the index is >= n
// ---------------------------------------------------------------------------
package seg_pkg;

  // Indexed by the hex value; element 0 is the code for digit 0.
  localparam logic [15:0][6:0] SEG_HEX_LUT = {
    7'h71, 7'h7b, 7'h5e, 7'h58,   // F E d c
    7'h7c, 7'h5f, 7'h6f, 7'h7f,   // b A 9 8
    7'h27, 7'h7d, 7'h6d, 7'h66,   // 7 6 5 4
    7'h4f, 7'h5b, 7'h06, 7'h3f    // 3 2 1 0
  };

  localparam int SEG_DOT_BIT = 7;

  typedef struct packed {
    logic       dot;
    logic [3:0] hex;
  } seg_entry_t;

  // Returned wide so callers with any digit count up to 16 can slice it.
  function automatic logic [15:0] onehot(input logic [31:0] idx,
                                         input logic [31:0] n);
    logic [15:0] r;
    r = '0;
    if ((idx < n) && (idx < 32'd16)) begin
      r[idx[3:0]] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg_scan_driver_if
// Write bus into the digit register file of seg_scan_driver.
//   wr_en   : write strobe
//   wr_addr : digit index to write ($clog2(NUM_DIGITS) bits)
//   wr_data : hex value for that digit
//   wr_dot  : decimal point for that digit
// master drives the bus (board register logic), slave receives it (driver).
// ---------------------------------------------------------------------------
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dot;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_dot
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input wr_dot
  );

endinterface

// File: rtl/seg_scan_driver_hex_decode.sv
// ---------------------------------------------------------------------------
// seg_hex_decode
// Combinational hex to 7-segment decoder, active-high segment codes.
//   hex : 4-bit hex digit in
//   seg : {g,f,e,d,c,b,a} out
// ---------------------------------------------------------------------------
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_HEX_LUT[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a multi-digit 7-segment display.
// A register file of hex digits (plus dots) is written over a simple bus and
// scanned one digit per SCAN_DIV clocks, with DEAD_CYC blank cycles at the
// start of each slot to avoid ghosting, and optional leading-zero blanking.
//   clk, rst  : clock, asynchronous active-high reset
//   wr        : register file write bus (slave side)
//   digit_en  : per-digit enable, 0 keeps that common inactive
//   lz_blank  : 1 enables leading-zero blanking
//   seg_d     : {dot,g,f,e,d,c,b,a}, registered, polarity per SEG_ACT_HIGH
//   seg_com   : one-hot digit select, registered, polarity per COM_ACT_HIGH
//   scan_tick : one-cycle pulse in the first cycle of a new scan index
// ---------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int DEAD_CYC     = 2,
  parameter bit SEG_ACT_HIGH = 1'b1,
  parameter bit COM_ACT_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_driver_if.slave      wr,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic                  lz_blank,
  output logic [7:0]            seg_d,
  output logic [NUM_DIGITS-1:0] seg_com,
  output logic                  scan_tick
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [AW-1:0]         IDX_LAST = AW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF  = SEG_ACT_HIGH ? 8'h00 : 8'hFF;
  localparam logic [NUM_DIGITS-1:0] COM_OFF  = COM_ACT_HIGH ? {NUM_DIGITS{1'b0}}
                                                            : {NUM_DIGITS{1'b1}};

  seg_entry_t            entries [NUM_DIGITS];
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         idx;
  logic                  wr_hit;
  seg_entry_t            cur;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] hex_zero;
  logic [NUM_DIGITS-1:0] lt_mask;
  logic                  blank;
  logic                  com_live;
  logic [15:0]           oh_full;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] com_next;

  // Out-of-range addresses (non power-of-two digit counts) are dropped.
  assign wr_hit = wr.wr_en && (int'(wr.wr_addr) < NUM_DIGITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_hit) begin
      entries[wr.wr_addr] <= '{dot: wr.wr_dot, hex: wr.wr_data};
    end
  end

  // Prescaler and scan index; the tick lands in the first cycle of the new index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      scan_tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + AW'(1);
      scan_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CW'(1);
      scan_tick <= 1'b0;
    end
  end

  assign cur = entries[idx];

  seg_hex_decode u_hex_decode (
    .hex (cur.hex),
    .seg (seg_raw)
  );

  // A digit is a leading zero when it and every digit above it hold zero:
  // every bit not below idx must be a zero digit.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign hex_zero[g] = (entries[g].hex == 4'h0);
    assign lt_mask[g]  = (AW'(g) < idx);
  end

  assign blank = lz_blank && (idx != '0) && (&(hex_zero | lt_mask));

  // Next output word; blanking only clears a..g, the dot stays visible.
  always_comb begin
    seg_next = '0;
    com_next = '0;
    oh_full  = onehot(32'(idx), 32'(NUM_DIGITS));
    com_live = (int'(cnt) >= DEAD_CYC) && digit_en[idx];

    seg_next[SEG_DOT_BIT] = cur.dot;
    seg_next[6:0]         = blank ? 7'h00 : seg_raw;
    if (com_live) begin
      com_next = oh_full[NUM_DIGITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_d   <= SEG_OFF;
      seg_com <= COM_OFF;
    end else begin
      seg_d   <= SEG_ACT_HIGH ? seg_next : ~seg_next;
      seg_com <= COM_ACT_HIGH ? com_next : ~com_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
// Drives two builds of seg_scan_driver from one stimulus stream:
//   dut_a : 4 digits, SCAN_DIV=4, DEAD_CYC=1, active-high segments/commons
//   dut_b : 3 digits, same timing, active-low segments/commons
// A reference model computes each cycle's display from the cycle count since
// reset and the digit contents, pushes it into a scoreboard queue, and a
// monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int SCAN = 4;
  localparam int DEAD = 1;

  typedef struct {
    logic [7:0] seg_a;
    logic [3:0] com_a;
    logic       tick_a;
    logic [7:0] seg_b;
    logic [2:0] com_b;
    logic       tick_b;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] digit_en;
  logic       lz_blank;
  logic [7:0] seg_a, seg_b;
  logic [3:0] com_a;
  logic [2:0] com_b;
  logic       tick_a, tick_b;

  int tests_run    = 0;
  int tests_failed = 0;

  seg_scan_driver_if #(.NUM_DIGITS(4)) bus_a ();
  seg_scan_driver_if #(.NUM_DIGITS(3)) bus_b ();

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(SCAN), .DEAD_CYC(DEAD),
    .SEG_ACT_HIGH(1'b1), .COM_ACT_HIGH(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .wr(bus_a), .digit_en(digit_en), .lz_blank(lz_blank),
    .seg_d(seg_a), .seg_com(com_a), .scan_tick(tick_a)
  );

  seg_scan_driver #(
    .NUM_DIGITS(3), .SCAN_DIV(SCAN), .DEAD_CYC(DEAD),
    .SEG_ACT_HIGH(1'b0), .COM_ACT_HIGH(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .wr(bus_b), .digit_en(digit_en[2:0]), .lz_blank(lz_blank),
    .seg_d(seg_b), .seg_com(com_b), .scan_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment codes straight from the digit shapes (gfedcba).
  function automatic logic [6:0] tb_lut(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3f;  4'h1: return 7'h06;  4'h2: return 7'h5b;  4'h3: return 7'h4f;
      4'h4: return 7'h66;  4'h5: return 7'h6d;  4'h6: return 7'h7d;  4'h7: return 7'h27;
      4'h8: return 7'h7f;  4'h9: return 7'h6f;  4'hA: return 7'h5f;  4'hB: return 7'h7c;
      4'hC: return 7'h58;  4'hD: return 7'h5e;  4'hE: return 7'h7b;  default: return 7'h71;
    endcase
  endfunction

  // Display after clock edge number c (counted from reset release), given the
  // digit contents and controls seen at that edge.
  function automatic void model_out(input logic [15:0][4:0] mem, input int n, input int c,
                                    input logic [15:0] en, input logic lz,
                                    input bit seg_hi, input bit com_hi,
                                    output logic [7:0] seg, output logic [15:0] com);
    int  pos, slot;
    bit  blank;
    pos   = c % SCAN;
    slot  = (c / SCAN) % n;
    blank = lz && (slot != 0);
    for (int j = slot; j < n; j++) begin
      if (mem[j][3:0] != 4'h0) blank = 1'b0;
    end
    seg = {mem[slot][4], blank ? 7'h00 : tb_lut(mem[slot][3:0])};
    if (!seg_hi) seg = ~seg;
    com = '0;
    if ((pos >= DEAD) && en[slot]) com[slot] = 1'b1;
    if (!com_hi) com = com ^ ((16'd1 << n) - 16'd1);
  endfunction

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one scoreboard entry per clock edge out of reset.
  exp_t             sb_q[$];
  logic [15:0][4:0] mem_a, mem_b;
  int               cyc;

  always @(posedge clk or posedge rst) begin
    exp_t        e;
    logic [15:0] ca, cb;
    if (rst) begin
      mem_a = '0;
      mem_b = '0;
      cyc   = 0;
      sb_q.delete();
    end else begin
      model_out(mem_a, 4, cyc, {12'b0, digit_en}, lz_blank, 1'b1, 1'b1, e.seg_a, ca);
      model_out(mem_b, 3, cyc, {12'b0, digit_en}, lz_blank, 1'b0, 1'b0, e.seg_b, cb);
      e.com_a  = ca[3:0];
      e.com_b  = cb[2:0];
      e.tick_a = ((cyc + 1) % SCAN) == 0;
      e.tick_b = e.tick_a;
      sb_q.push_back(e);
      if (bus_a.wr_en) begin
        mem_a[bus_a.wr_addr] = {bus_a.wr_dot, bus_a.wr_data};
        if (bus_a.wr_addr < 2'd3) mem_b[bus_a.wr_addr] = {bus_a.wr_dot, bus_a.wr_data};
      end
      cyc++;
    end
  end

  // Monitor: the outputs are valid every cycle once reset is released.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (sb_q.size() > 0)) begin
      e = sb_q.pop_front();
      check_output("seg_d_a",     {8'h0, seg_a},  {8'h0, e.seg_a});
      check_output("seg_com_a",   {12'h0, com_a}, {12'h0, e.com_a});
      check_output("scan_tick_a", {15'h0, tick_a}, {15'h0, e.tick_a});
      check_output("seg_d_b",     {8'h0, seg_b},  {8'h0, e.seg_b});
      check_output("seg_com_b",   {13'h0, com_b}, {13'h0, e.com_b});
      check_output("scan_tick_b", {15'h0, tick_b}, {15'h0, e.tick_b});
    end
  end

  task automatic apply_stimulus(input logic we, input logic [1:0] addr,
                                input logic [3:0] data, input logic dot);
    @(negedge clk);
    bus_a.wr_en   = we;  bus_a.wr_addr = addr;  bus_a.wr_data = data;  bus_a.wr_dot = dot;
    bus_b.wr_en   = we;  bus_b.wr_addr = addr;  bus_b.wr_data = data;  bus_b.wr_dot = dot;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 2'd0, 4'h0, 1'b0);
  endtask

  // Checked while rst is high, away from any clock edge.
  task automatic check_reset_values(input string tag);
    check_output({tag, "_seg_a"},  {8'h0, seg_a},   16'h0000);
    check_output({tag, "_com_a"},  {12'h0, com_a},  16'h0000);
    check_output({tag, "_tick_a"}, {15'h0, tick_a}, 16'h0000);
    check_output({tag, "_seg_b"},  {8'h0, seg_b},   16'h00FF);
    check_output({tag, "_com_b"},  {13'h0, com_b},  16'h0007);
    check_output({tag, "_tick_b"}, {15'h0, tick_b}, 16'h0000);
  endtask

  initial begin
    logic [3:0] d;
    rst      = 1'b0;
    digit_en = 4'b1111;
    lz_blank = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_dot = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_dot = 1'b0;
    #1 rst = 1'b1;
    #2 check_reset_values("reset_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Digits 3..0 = 1,2,3,F with the dot on digit 0.
    apply_stimulus(1'b1, 2'd3, 4'h1, 1'b0);
    apply_stimulus(1'b1, 2'd2, 4'h2, 1'b0);
    apply_stimulus(1'b1, 2'd1, 4'h3, 1'b0);
    apply_stimulus(1'b1, 2'd0, 4'hF, 1'b1);
    idle(32);

    // Leading zeros: digits 3..0 = 0,0,5,0, blanking on then off.
    apply_stimulus(1'b1, 2'd3, 4'h0, 1'b0);
    apply_stimulus(1'b1, 2'd2, 4'h0, 1'b0);
    apply_stimulus(1'b1, 2'd1, 4'h5, 1'b0);
    apply_stimulus(1'b1, 2'd0, 4'h0, 1'b0);
    lz_blank = 1'b1;
    idle(24);
    lz_blank = 1'b0;
    idle(24);

    // Disabled digit 2, then re-enabled.
    digit_en = 4'b1011;
    idle(24);
    digit_en = 4'b1111;

    // Address 3 is out of range for the 3-digit build; then write an "8".
    apply_stimulus(1'b1, 2'd3, 4'h9, 1'b1);
    apply_stimulus(1'b1, 2'd1, 4'h8, 1'b0);
    idle(24);

    // Writes landing on whichever digit is being scanned at the time.
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(1'b1, 2'((i / SCAN) % 3), 4'(i), 1'(i));
    end
    idle(8);

    // Asynchronous reset in the middle of a slot.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("reset_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);

    // Randomised traffic, biased towards zero digits so blanking gets exercised.
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
                     1'($urandom_range(0, 1)));
      if (i == 1500) begin
        #3 rst = 1'b1;
        #1 check_reset_values("reset_rand");
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
